// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared constants and helpers for the round-robin registered mux.
// Optional build macro used by this block: RR_MUX_PRIO_EN (see rr_arbiter).
package rr_mux_pkg;

    localparam int RR_MUX_WIDTH = 16;
    localparam int RR_MUX_N     = 4;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter that owns the rotation pointer.
// Build option RR_MUX_PRIO_EN: channel 0 wins whenever it requests and does not
// move the pointer; channels 1..N-1 rotate among themselves.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int N  = RR_MUX_N,
    localparam int SW = (N > 1) ? clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] idx,
    output logic          any
);

    logic [SW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  rr_req;
    logic          prio_hit;
    int            j;

    // Grant select: scan requests starting at ptr, wrapping modulo N.
    always_comb begin
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        rr_req = req;
`ifdef RR_MUX_PRIO_EN
        prio_hit  = req[0];
        rr_req[0] = 1'b0;
`else
        prio_hit  = 1'b0;
`endif
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && rr_req[j]) begin
                any = 1'b1;
                idx = SW'(j);
            end
        end
        if (prio_hit) begin
            any = 1'b1;
            idx = '0;
        end
        if (any) begin
            grant = N'(1) << idx;
        end
    end

    // Pointer moves past the winner only on an accepted round-robin grant.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && any && !prio_hit) begin
            ptr_d = (int'(idx) == N - 1) ? '0 : idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-input WIDTH-bit registered mux with valid/ready handshakes and
// round-robin arbitration. One output register, one-cycle latency, no bubble on
// simultaneous drain and fill. Build option RR_MUX_PRIO_EN (channel 0 priority)
// lives in rr_arbiter; the interface is the same in both builds.
module rr_mux_reg
    import rr_mux_pkg::*;
#(
    parameter  int WIDTH = RR_MUX_WIDTH,
    parameter  int N     = RR_MUX_N,
    localparam int SW    = (N > 1) ? clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SW-1:0]      out_sel
);

    logic             load;
    logic [N-1:0]     grant;
    logic [SW-1:0]    gidx;
    logic             any;
    logic [WIDTH-1:0] mux_word;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic             valid_q, valid_d;

    assign load = !valid_q || out_ready;

    rr_arbiter #(.N(N)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (in_valid),
        .advance (load),
        .grant   (grant),
        .idx     (gidx),
        .any     (any)
    );

    assign in_ready = load ? grant : '0;

    // AND-OR data mux over the one-hot grant.
    always_comb begin
        mux_word = '0;
        for (int i = 0; i < N; i++) begin
            mux_word = mux_word | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    // Output register next state: load a granted word, empty on idle, hold on stall.
    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (load) begin
            valid_d = any;
            if (any) begin
                data_d = mux_word;
                sel_d  = gidx;
            end
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule

// File: doc/rr_mux_reg.md
# rr_mux_reg

Parametrised successor to the team's 1-bit 2:1 mux. It is an N-input, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes and round-robin arbitration. It replaces hand-replicated mux slices in the datapath wherever several producers share one consumer, such as register-file write-back and bus-source selection. A single output register gives one-cycle latency at full throughput.

## Interface
- WIDTH, 16: data bits per channel.
- N, 4: number of input channels; 1..16, need not be a power of 2.
- SW, max(1, clog2(N)): select/index width; derived, not overridden.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  channel i offers a word.
- in_ready  out  N  channel i word accepted this cycle.
- out_data  out  WIDTH  registered selected word.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- out_sel  out  SW  index of the channel that supplied out_data.

## Operation
- Reset state: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
- load = !out_valid || out_ready. The output register is free or is being drained this cycle.
- Grant g = first i with in_valid[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
- in_ready[i] = load && any(in_valid) && i==g. At most one bit is set. in_ready is combinational from in_valid, out_valid, out_ready and ptr.
- On a clock with load=1 and any(in_valid)=1:
  - out_data <= channel g word.
  - out_sel <= g.
  - out_valid <= 1.
  - ptr <= (g+1) mod N; ptr=N-1 wraps to 0.
- On a clock with load=1 and no in_valid: out_valid <= 0. out_data and out_sel hold.
- On a clock with load=0 (stall): the register, out_sel and ptr all hold. All in_ready are 0.
- Simultaneous drain and fill: with out_valid=1 and out_ready=1, a new word loads in the same cycle. There is no bubble.
- ptr advances only on an accepted transfer. It never advances on idle or stall cycles.
- N=1: the grant is always 0, ptr stays 0, and out_sel stays 0.
- Producers must hold in_valid and in_data until in_ready. Dropping a word early is a protocol error and is not checked.
- Asserting rst_n mid-operation discards the held word immediately (asynchronous) and returns every register to its reset value.

## Timing
- Latency: 1 cycle from the in_valid/in_ready transfer edge to out_valid.
- Throughput: 1 word/cycle while out_ready=1.
- Fairness: with all N channels continuously valid, each channel is granted exactly once every N transfers.
- No combinational path from in_data to out_data.
- Combinational path out_ready -> in_ready, depth O(N).

## Configuration
- RR_MUX_PRIO_EN defined:
  - Channel 0 has strict priority. If in_valid[0]=1, then g=0 regardless of ptr.
  - ptr is not updated on a channel-0 grant.
  - Channels 1..N-1 rotate round-robin among themselves when channel 0 is idle.
- RR_MUX_PRIO_EN undefined: pure round-robin over all N channels as in Operation.
- The interface is identical in both builds.

## Structure
- Shared package rr_mux_pkg holds:
  - The clog2 constant function.
  - Default constants RR_MUX_WIDTH=16 and RR_MUX_N=4.
- One sub-module, rr_arbiter:
  - Inputs: req[N], advance, ptr state.
  - Outputs: one-hot grant and binary index.
  - Owns ptr and the RR_MUX_PRIO_EN logic.
- The top level holds the output register and the data mux, an AND-OR reduction over the one-hot grant.

## Test plan
- Reset: drive rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 asynchronously. The first grant after release is channel 0.
- Single channel: N=4, only ch2 valid with 0xA5A5 and out_ready=1 -> in_ready=0100, then out_data=0xA5A5 and out_sel=2 one cycle later, and ptr=3.
- Fairness and wrap: all 4 channels valid with out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3.
- Stall: out_valid=1, out_ready=0 for 3 cycles with ch1 valid -> in_ready=0000, out_data stable, ptr unchanged. On release, ch1 loads with no bubble.
- Non-power-of-2: N=3, WIDTH=8, ptr=2, ch0 and ch1 valid -> grant ch0 and ptr=1.
- RR_MUX_PRIO_EN build: ch0 and ch3 valid for 3 cycles -> out_sel 0,0,0. Drop ch0 -> out_sel 3 on the next transfer.
